// File: rtl/prog_clk_divider_pkg.sv
// Shared types and helpers for the programmable clock divider: channel FSM states,
// channel-select width and the div/high clamping rules applied when a config is accepted.
package prog_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ch_state_e;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

    // High time must leave at least one low cycle, so it is capped at div-1.
    function automatic logic [31:0] clamp_high(input logic [31:0] high, input logic [31:0] div);
        logic [31:0] h;
        h = (high < 32'd1) ? 32'd1 : high;
        return (h > div - 32'd1) ? div - 32'd1 : h;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Config write channel of the divider: one valid/ready beat carries channel, period and high time.
// Ready is combinational on the addressed channel's pending flag.
interface prog_clk_divider_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/prog_clk_divider_channel.sv
// One divider channel: IDLE/RUN/STOP FSM, period counter, active and pending div/high registers.
// O_CLK/O_TICK are registered; a pending config is taken only at a period boundary (or at once when idle).
module div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 20
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic [CNT_W-1:0] wr_high_i,
    output logic             pend_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] high_act_q, high_act_d;
    logic [CNT_W-1:0] div_pnd_q, div_pnd_d;
    logic [CNT_W-1:0] high_pnd_q, high_pnd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] wr_div_c, wr_high_c;
    logic             wrap;

    assign wr_div_c  = CNT_W'(clamp_div(32'(wr_div_i)));
    assign wr_high_c = CNT_W'(clamp_high(32'(wr_high_i), 32'(wr_div_c)));
    assign wrap      = (state_q != IDLE) && (cnt_q == div_act_q - ONE);

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_act_q  <= RST_DIV;
            high_act_q <= RST_HIGH;
            div_pnd_q  <= '0;
            high_pnd_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            high_act_q <= high_act_d;
            div_pnd_q  <= div_pnd_d;
            high_pnd_q <= high_pnd_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    // STOP keeps counting so the current period always completes in full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (!en_i) state_d = STOP;
            STOP: begin
                if (en_i)      state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        clk_d      = 1'b0;
        tick_d     = 1'b0;
        div_act_d  = div_act_q;
        high_act_d = high_act_q;
        div_pnd_d  = div_pnd_q;
        high_pnd_d = high_pnd_q;
        pend_d     = pend_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            // An idle channel takes a new config directly so a same-cycle start already uses it.
            if (wr_en_i) begin
                div_act_d  = wr_div_c;
                high_act_d = wr_high_c;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                div_act_d  = div_pnd_q;
                high_act_d = high_pnd_q;
                pend_d     = 1'b0;
            end
            if (en_i) begin
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end
        end else begin
            if (wrap) begin
                cnt_d = '0;
                if (pend_q) begin
                    div_act_d  = div_pnd_q;
                    high_act_d = high_pnd_q;
                    pend_d     = 1'b0;
                end
                if (state_d != IDLE) begin
                    clk_d  = 1'b1;
                    tick_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
                clk_d = (cnt_d < high_act_q);
            end
            // Sampled after the apply above, so a write in the wrap cycle waits one more period.
            if (wr_en_i) begin
                div_pnd_d  = wr_div_c;
                high_pnd_d = wr_high_c;
                pend_d     = 1'b1;
            end
        end
    end

    assign pend_o   = pend_q;
    assign clk_o    = clk_q;
    assign tick_o   = tick_q;
    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/prog_clk_divider.sv
// NCH-channel runtime-programmable clock divider; outputs registered, 1 cycle from en to first O_CLK edge.
// Config ready drops only while the addressed channel holds an unapplied config; writes to cfg_ch >= NCH are dropped.
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 20
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    prog_clk_divider_if.slave cfg,
    output logic [NCH-1:0]   O_CLK,
    output logic [NCH-1:0]   O_TICK,
    output logic [NCH-1:0]   active
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr_en;
    logic [31:0]    cfg_ch_idx;

    assign cfg_ch_idx = 32'(cfg.cfg_ch);

    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_ch_idx == 32'(c)) cfg.cfg_ready = ~pend[c];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign wr_en[c] = cfg.cfg_valid && cfg.cfg_ready && (cfg_ch_idx == 32'(c));

        div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .I_CLK     (I_CLK),
            .rst       (rst),
            .en_i      (en[c]),
            .wr_en_i   (wr_en[c]),
            .wr_div_i  (cfg.cfg_div),
            .wr_high_i (cfg.cfg_high),
            .pend_o    (pend[c]),
            .clk_o     (O_CLK[c]),
            .tick_o    (O_TICK[c]),
            .active_o  (active[c])
        );
    end

endmodule
